car_pass_generator: RTL and testbench
=====================================

Name: car_pass_generator

Overview:
- Sensor-side counterpart of the parking-meter entry detector: on request, drives the two photo-sensor lines `entra`/`sale` with the exact waveform a vehicle produces when passing through the barrier.
- Entry sequence is 10 → 00 → 01 → 00; exit sequence is the reverse, 01 → 00 → 10 → 00.
- Used for on-board demo (button-driven) and as a synthesizable stimulus source in front of the detector FSM.

Parameters:
- PHASE_CYCLES, 4, clock cycles each sensor-active phase and the trailing idle phase last; legal range ≥1.
- GAP_CYCLES, 2, cycles of 00 between first and second sensor phases; legal range ≥0, 0 means the phase is skipped.
- CNT_W, 8, width of the pass counters.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset (reset=0 on a rising edge clears state)
- start_in  input  1  request an entry pass; sampled only in IDLE
- start_out  input  1  request an exit pass; sampled only in IDLE
- entra  output  1  entry-side sensor line, registered
- sale  output  1  exit-side sensor line, registered
- busy  output  1  high while a pass sequence is being driven
- done  output  1  one-cycle pulse in the final cycle of a sequence
- n_in  output  CNT_W  completed entry passes
- n_out  output  CNT_W  completed exit passes

Behaviour:
- Reset (reset=0 at clock edge): state IDLE, entra=0, sale=0, busy=0, done=0, n_in=0, n_out=0, phase counter=0, direction flag=0.
- Reset applies mid-sequence too: outputs return to 00 on that edge and no counter increments.
- States: IDLE, FIRST, GAP, SECOND, TAIL. A direction flag (0=in, 1=out) is latched when leaving IDLE.
- IDLE:
  - start_in=1 at edge t → FIRST, dir=in.
  - Otherwise start_out=1 → FIRST, dir=out.
  - start_in has priority when both are high; start_out is dropped, not queued.
- FIRST (PHASE_CYCLES cycles):
  - dir=in drives {entra,sale}=10; dir=out drives 01.
  - Next state is GAP, or SECOND if GAP_CYCLES=0.
- GAP (GAP_CYCLES cycles): drives 00 → SECOND.
- SECOND (PHASE_CYCLES cycles): drives the opposite sensor (in: 01, out: 10) → TAIL.
- TAIL (PHASE_CYCLES cycles): drives 00. done=1 in the last TAIL cycle, then → IDLE.
- Output timing:
  - Outputs are registered, so the first FIRST-phase value appears in cycle t+1.
  - busy=1 from t+1 through the cycle carrying done, so busy lasts exactly 3*PHASE_CYCLES+GAP_CYCLES cycles.
  - busy=0 in IDLE.
- A new start may be accepted in the cycle immediately after done, giving back-to-back sequences with one IDLE cycle between them.
- start_in/start_out while busy=1 are ignored.
- Counters:
  - n_in or n_out increments by 1 on the edge ending the done cycle; the new value is visible together with busy=0.
  - Counters wrap modulo 2^CNT_W with no saturation.
- entra and sale are never simultaneously 1 (without the optional feature).
- Phase counter is a down-counter loaded on each state entry, sized for max(PHASE_CYCLES, GAP_CYCLES, 1).

Optional Feature:
- Macro CAR_OVERLAP_EN.
- Defined:
  - GAP phase drives 11 (both sensors blocked, long vehicle) instead of 00, for both directions.
  - Adds output `overlap` (1 bit), high during GAP.
  - With GAP_CYCLES=0, behaviour is identical to undefined.
- Undefined: GAP drives 00, no `overlap` port, and 11 is never produced.

Test Plan:
- Defaults, start_in pulse at cycle 0 → cycles 1-4 = 10, 5-6 = 00, 7-10 = 01, 11-14 = 00; busy high 1-14; done only at 14; n_in=1, busy=0 at 15; n_out=0.
- Defaults, start_out at cycle 0 → cycles 1-4 = 01, 5-6 = 00, 7-10 = 10, 11-14 = 00; n_out=1 at 15.
- start_in and start_out high together in IDLE → entry sequence only; n_in=1, n_out=0. start_in re-pulsed at cycle 6 → ignored, one pass only.
- GAP_CYCLES=0, PHASE_CYCLES=1 → 10, 01, 00, then IDLE; busy 3 cycles. CNT_W=2 with 5 entries → n_in reaches 3, then wraps to 0, then 1.
- reset=0 at cycle 8 of an entry → outputs 00, busy=0, done=0 at the next edge; n_in unchanged. Sequence restarts cleanly on a new start_in.
- CAR_OVERLAP_EN defined, defaults, start_in → cycles 5-6 = 11 with overlap=1; all other cycles as in the first scenario.

Source files
------------

// File: rtl/car_pass_generator.sv
// car_pass_generator
// Drives the entra/sale photo-sensor lines with the waveform a vehicle makes
// passing the barrier:
//   entry : 10 -> 00 -> 01 -> 00
//   exit  : 01 -> 00 -> 10 -> 00
// Useful as a demo source (button driven) or as synthesizable stimulus placed
// in front of the entry-detector FSM.
//
// Optional build macro: CAR_OVERLAP_EN
//   When defined, the GAP phase drives 11 (both sensors blocked, as a long
//   vehicle would) and an extra `overlap` output is high during GAP.
//   When undefined, GAP drives 00, 11 never appears and `overlap` is absent.
//
// State table
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for start_in / start_out, lines at 00
//   S_FIRST  | first sensor blocked (in: entra, out: sale), PHASE_CYCLES
//   S_GAP    | between sensors (00, or 11 with overlap), GAP_CYCLES
//   S_SECOND | second sensor blocked (in: sale, out: entra), PHASE_CYCLES
//   S_TAIL   | vehicle gone, lines at 00, done in the last cycle

module car_pass_generator #(
   parameter int PHASE_CYCLES = 4,
   parameter int GAP_CYCLES   = 2,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_in,
   input  logic             start_out,
   output logic             entra,
   output logic             sale,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] n_in,
   output logic [CNT_W-1:0] n_out
`ifdef CAR_OVERLAP_EN
   ,
   output logic             overlap
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FIRST  = 3'd1,
      S_GAP    = 3'd2,
      S_SECOND = 3'd3,
      S_TAIL   = 3'd4
   } state_t;

   // Phase counter holds "cycles remaining minus one" so a phase ends when it
   // reads zero; it only ever needs to hold max(PHASE, GAP, 1) - 1.
   localparam int MAX_CYC = (PHASE_CYCLES > GAP_CYCLES) ?
                            ((PHASE_CYCLES > 1) ? PHASE_CYCLES : 1) :
                            ((GAP_CYCLES > 1) ? GAP_CYCLES : 1);
   localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CW-1:0] PH_LOAD  = CW'(PHASE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic          HAS_GAP  = (GAP_CYCLES > 0);

`ifdef CAR_OVERLAP_EN
   localparam logic [1:0] GAP_LINES = 2'b11;
`else
   localparam logic [1:0] GAP_LINES = 2'b00;
`endif

   state_t          state_q, state_nxt;
   logic [CW-1:0]   cnt_q, cnt_nxt;
   logic            dir_q, dir_nxt;      // 0 = entry, 1 = exit

   logic [1:0]      lines_nxt;           // {entra, sale}
   logic            busy_nxt;
   logic            done_nxt;
   logic            overlap_nxt;

   logic [1:0]      lines_q;
   logic            overlap_q;

   // State, phase counter and direction flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         dir_q   <= dir_nxt;
      end
   end

   // Next state: each phase runs until the down-counter hits zero, then the
   // counter is reloaded for the following phase
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      dir_nxt   = dir_q;
      case (state_q)
         S_IDLE: begin
            // start_in wins a tie; a losing start_out is simply dropped
            if (start_in) begin
               state_nxt = S_FIRST;
               dir_nxt   = 1'b0;
               cnt_nxt   = PH_LOAD;
            end else if (start_out) begin
               state_nxt = S_FIRST;
               dir_nxt   = 1'b1;
               cnt_nxt   = PH_LOAD;
            end
         end
         S_FIRST: begin
            if (cnt_q == '0) begin
               if (HAS_GAP) begin
                  state_nxt = S_GAP;
                  cnt_nxt   = GAP_LOAD;
               end else begin
                  state_nxt = S_SECOND;
                  cnt_nxt   = PH_LOAD;
               end
            end else begin
               cnt_nxt = cnt_q - CW'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == '0) begin
               state_nxt = S_SECOND;
               cnt_nxt   = PH_LOAD;
            end else begin
               cnt_nxt = cnt_q - CW'(1);
            end
         end
         S_SECOND: begin
            if (cnt_q == '0) begin
               state_nxt = S_TAIL;
               cnt_nxt   = PH_LOAD;
            end else begin
               cnt_nxt = cnt_q - CW'(1);
            end
         end
         S_TAIL: begin
            if (cnt_q == '0) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_q - CW'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Output decode from the upcoming state so the registered lines line up
   // with the state they describe
   always_comb begin
      lines_nxt   = 2'b00;
      overlap_nxt = 1'b0;
      busy_nxt    = (state_nxt != S_IDLE);
      done_nxt    = (state_nxt == S_TAIL) && (cnt_nxt == '0);
      case (state_nxt)
         S_FIRST:  lines_nxt = dir_nxt ? 2'b01 : 2'b10;
         S_GAP: begin
            lines_nxt   = GAP_LINES;
            overlap_nxt = 1'b1;
         end
         S_SECOND: lines_nxt = dir_nxt ? 2'b10 : 2'b01;
         default:  lines_nxt = 2'b00;
      endcase
   end

   // Registered sensor lines and status flags
   always_ff @(posedge clk) begin
      if (!reset) begin
         lines_q   <= 2'b00;
         busy      <= 1'b0;
         done      <= 1'b0;
         overlap_q <= 1'b0;
      end else begin
         lines_q   <= lines_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         overlap_q <= overlap_nxt;
      end
   end

   // Pass counters bump on the edge that closes the done cycle; dir_q still
   // holds the direction of the pass that just finished
   always_ff @(posedge clk) begin
      if (!reset) begin
         n_in  <= '0;
         n_out <= '0;
      end else if (done) begin
         if (dir_q)
            n_out <= n_out + CNT_W'(1);
         else
            n_in  <= n_in + CNT_W'(1);
      end
   end

   assign entra = lines_q[1];
   assign sale  = lines_q[0];

`ifdef CAR_OVERLAP_EN
   assign overlap = overlap_q;
`else
   // Without the overlap build the flag is only an internal decode
   logic unused_overlap;
   assign unused_overlap = overlap_q;
`endif

endmodule

// File: tb/tb_car_pass_generator.sv
// Directed bench for car_pass_generator: a default-parameter instance (A) and
// a PHASE_CYCLES=1 / GAP_CYCLES=0 / CNT_W=2 instance (B).
// Build macro CAR_OVERLAP_EN switches the expected GAP lines to 11.

module tb_car_pass_generator;

   logic       clk = 1'b0;
   logic       reset;

   logic       start_in_a, start_out_a;
   logic       entra_a, sale_a, busy_a, done_a;
   logic [7:0] n_in_a, n_out_a;

   logic       start_in_b, start_out_b;
   logic       entra_b, sale_b, busy_b, done_b;
   logic [1:0] n_in_b, n_out_b;

`ifdef CAR_OVERLAP_EN
   logic       overlap_a, overlap_b;
   localparam logic [1:0] GAP_V = 2'b11;
`else
   localparam logic [1:0] GAP_V = 2'b00;
`endif

   int errors = 0;
   int checks = 0;
   int exp_in_a  = 0;
   int exp_out_a = 0;

   always #5 clk = ~clk;

   car_pass_generator #(.PHASE_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8)) dut_a (
      .clk       (clk),
      .reset     (reset),
      .start_in  (start_in_a),
      .start_out (start_out_a),
      .entra     (entra_a),
      .sale      (sale_a),
      .busy      (busy_a),
      .done      (done_a),
      .n_in      (n_in_a),
      .n_out     (n_out_a)
`ifdef CAR_OVERLAP_EN
      ,
      .overlap   (overlap_a)
`endif
   );

   car_pass_generator #(.PHASE_CYCLES(1), .GAP_CYCLES(0), .CNT_W(2)) dut_b (
      .clk       (clk),
      .reset     (reset),
      .start_in  (start_in_b),
      .start_out (start_out_b),
      .entra     (entra_b),
      .sale      (sale_b),
      .busy      (busy_b),
      .done      (done_b),
      .n_in      (n_in_b),
      .n_out     (n_out_b)
`ifdef CAR_OVERLAP_EN
      ,
      .overlap   (overlap_b)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Caller has driven the start request during cycle 0; checks cycles 1..15
   // of a default-parameter pass on instance A. pulse_at re-asserts start_in
   // during that cycle to show it is ignored while busy.
   task automatic run_a(input logic dir_out, input int pulse_at);
      logic [1:0] first_v, second_v, exp_lines;
      first_v  = dir_out ? 2'b01 : 2'b10;
      second_v = dir_out ? 2'b10 : 2'b01;
      if (dir_out) exp_out_a++; else exp_in_a++;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (c <= 4)       exp_lines = first_v;
         else if (c <= 6)  exp_lines = GAP_V;
         else if (c <= 10) exp_lines = second_v;
         else              exp_lines = 2'b00;
         chk($sformatf("a_lines d%0d c%0d", dir_out, c), {entra_a, sale_a}, exp_lines);
         chk($sformatf("a_busy d%0d c%0d", dir_out, c), busy_a, (c <= 14));
         chk($sformatf("a_done d%0d c%0d", dir_out, c), done_a, (c == 14));
`ifdef CAR_OVERLAP_EN
         chk($sformatf("a_overlap d%0d c%0d", dir_out, c), overlap_a, (c == 5 || c == 6));
`endif
         start_in_a  = (c == pulse_at);
         start_out_a = 1'b0;
      end
      chk($sformatf("a_n_in d%0d", dir_out), n_in_a, exp_in_a);
      chk($sformatf("a_n_out d%0d", dir_out), n_out_a, exp_out_a);
      @(negedge clk);
      chk($sformatf("a_idle_after d%0d", dir_out), busy_a, 1'b0);
      chk($sformatf("a_n_in_hold d%0d", dir_out), n_in_a, exp_in_a);
   endtask

   initial begin
      reset       = 1'b0;
      start_in_a  = 1'b0;
      start_out_a = 1'b0;
      start_in_b  = 1'b0;
      start_out_b = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_lines", {entra_a, sale_a}, 2'b00);
      chk("rst_busy",  busy_a, 1'b0);
      chk("rst_done",  done_a, 1'b0);
      chk("rst_n_in",  n_in_a, 0);
      chk("rst_n_out", n_out_a, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_busy", busy_a, 1'b0);

      // Reset in cycle 8 of an entry pass (counters were 0 and stay 0)
      start_in_a = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         start_in_a = 1'b0;
      end
      chk("midrst_pre_lines", {entra_a, sale_a}, 2'b01);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("midrst_lines", {entra_a, sale_a}, 2'b00);
      chk("midrst_busy",  busy_a, 1'b0);
      chk("midrst_done",  done_a, 1'b0);
      chk("midrst_n_in",  n_in_a, 0);
      @(negedge clk);
      chk("midrst_stays_idle", busy_a, 1'b0);

      // Clean restart after reset
      start_in_a = 1'b1;
      run_a(1'b0, 0);

      // Plain entry pass
      @(negedge clk);
      start_in_a = 1'b1;
      run_a(1'b0, 0);

      // Plain exit pass
      @(negedge clk);
      start_out_a = 1'b1;
      run_a(1'b1, 0);

      // Both requests together: entry only; start_in re-pulsed at cycle 6
      @(negedge clk);
      start_in_a  = 1'b1;
      start_out_a = 1'b1;
      run_a(1'b0, 6);
      repeat (3) @(negedge clk);
      chk("tie_no_extra_busy", busy_a, 1'b0);
      chk("tie_n_in",  n_in_a, exp_in_a);
      chk("tie_n_out", n_out_a, exp_out_a);

      // Instance B: 10, 01, 00 then IDLE, back-to-back, CNT_W=2 wrap
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         logic [1:0] exp_b;
         exp_b = 2'(k + 1);
         start_in_b = 1'b1;
         @(negedge clk);
         start_in_b = 1'b0;
         chk($sformatf("b_lines1 k%0d", k), {entra_b, sale_b, busy_b, done_b}, 4'b1010);
         @(negedge clk);
         chk($sformatf("b_lines2 k%0d", k), {entra_b, sale_b, busy_b, done_b}, 4'b0110);
         @(negedge clk);
         chk($sformatf("b_lines3 k%0d", k), {entra_b, sale_b, busy_b, done_b}, 4'b0011);
`ifdef CAR_OVERLAP_EN
         chk($sformatf("b_overlap k%0d", k), overlap_b, 1'b0);
`endif
         @(negedge clk);
         chk($sformatf("b_idle k%0d", k), {entra_b, sale_b, busy_b, done_b}, 4'b0000);
         chk($sformatf("b_n_in k%0d", k), n_in_b, exp_b);
         chk($sformatf("b_n_out k%0d", k), n_out_b, 2'b00);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
